// File: rtl/adaptive_fir_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adaptive_filter_pkg
//  Purpose  : Shared widths, mode configuration table and FSM states for the
//             multi-mode adaptive FIR.
//  Revision : 1.0
// ============================================================================
package adaptive_filter_pkg;

   localparam int C_IN_WL     = 14;
   localparam int C_IN_FL     = 6;
   localparam int C_OUT_WL    = 14;
   localparam int C_OUT_FL    = 6;
   localparam int C_COEF_WL   = 16;
   localparam int C_COEF_FL   = 14;
   localparam int C_TAPS      = 11;
   localparam int C_NUM_MODES = 2;
   localparam int C_FB_DELAY  = 2;
   localparam int C_ACC_GUARD = 4;
   localparam int C_NCOEF     = C_TAPS / 2 + 1;

   typedef struct packed {
      logic [C_NCOEF-1:0][C_COEF_WL-1:0] coef;
      logic                              symmetric;
      logic                              fb_en;
      logic [C_COEF_WL-1:0]              fb_coef;
   } mode_cfg_t;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   function automatic int f_acc_wl(input int in_wl, input int coef_wl,
                                   input int taps, input int guard);
      return in_wl + 1 + coef_wl + $clog2(taps) + guard;
   endfunction

   // coef[k] pairs x[n-k] with x[n-TAPS+1+k]; coef[TAPS/2] is the centre tap
   function automatic mode_cfg_t f_mode_cfg(input int m);
      mode_cfg_t cfg;
      cfg = '0;
      if (m == 0) begin
         cfg.coef[0] = 16'(164);
         cfg.coef[1] = 16'(-492);
         cfg.coef[2] = 16'(1311);
         cfg.coef[3] = 16'(-3277);
         cfg.coef[4] = 16'(9830);
         cfg.coef[5] = 16'(0);
      end else begin
         cfg.coef[0]   = 16'(164);
         cfg.coef[1]   = 16'(328);
         cfg.coef[2]   = 16'(655);
         cfg.coef[3]   = 16'(983);
         cfg.coef[4]   = 16'(1311);
         cfg.coef[5]   = 16'(1638);
         cfg.symmetric = 1'b1;
         cfg.fb_en     = 1'b1;
         cfg.fb_coef   = 16'(16384);
      end
      return cfg;
   endfunction

   localparam mode_cfg_t MODE_CFG [C_NUM_MODES] = '{f_mode_cfg(0), f_mode_cfg(1)};

endpackage
`default_nettype wire

// File: rtl/adaptive_fir_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : adaptive_fir_mc_if
//  Purpose  : Sample-in / sample-out stream bundle of the adaptive FIR.
//  Revision : 1.0
// ============================================================================
interface adaptive_fir_mc_if #(
   parameter int IN_WL  = 14,
   parameter int OUT_WL = 14
);
   logic signed [IN_WL-1:0]  s_tdata;
   logic                     s_tvalid;
   logic                     s_tready;
   logic signed [OUT_WL-1:0] m_tdata;
   logic                     m_tvalid;
   logic                     m_tovf;

   modport slave  (input  s_tdata, s_tvalid, output s_tready, m_tdata, m_tvalid, m_tovf);
   modport master (output s_tdata, s_tvalid, input  s_tready, m_tdata, m_tvalid, m_tovf);
endinterface
`default_nettype wire

// File: rtl/adaptive_fir_mc_round_sat.sv
`default_nettype none
// ============================================================================
//  Module   : fxp_round_sat
//  Purpose  : Round-half-up and saturate a wide accumulator to the output word.
//  Revision : 1.0
// ============================================================================
module fxp_round_sat #(
   parameter int IN_WL  = 39,
   parameter int IN_FL  = 20,
   parameter int OUT_WL = 14,
   parameter int OUT_FL = 6
) (
   input  wire logic signed [IN_WL-1:0]  i_acc,
   output logic signed [OUT_WL-1:0]      o_data,
   output logic                          o_ovf
);
   localparam int SHIFT  = IN_FL - OUT_FL;
   localparam int RND_WL = IN_WL + 1;
   localparam int SHR_WL = RND_WL - SHIFT;
   localparam logic signed [SHR_WL-1:0] C_MAX = {{(SHR_WL-OUT_WL+1){1'b0}}, {(OUT_WL-1){1'b1}}};
   localparam logic signed [SHR_WL-1:0] C_MIN = ~C_MAX;

   logic signed [RND_WL-1:0] w_rnd;
   logic signed [SHR_WL-1:0] w_shr;

   assign w_rnd = RND_WL'(i_acc) + (RND_WL'(1) << (SHIFT - 1));
   assign w_shr = SHR_WL'(w_rnd >>> SHIFT);

   always_comb begin
      o_ovf  = 1'b0;
      o_data = w_shr[OUT_WL-1:0];
      if (w_shr > C_MAX) begin
         o_data = C_MAX[OUT_WL-1:0];
         o_ovf  = 1'b1;
      end else if (w_shr < C_MIN) begin
         o_data = C_MIN[OUT_WL-1:0];
         o_ovf  = 1'b1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/adaptive_fir_mc.sv
`default_nettype none
// ============================================================================
//  Module   : adaptive_fir_mc
//  Purpose  : Folded multi-mode FIR with optional recursive tap and flush on
//             mode change; rounded, saturated output.
//  Revision : 1.0
// ============================================================================
module adaptive_fir_mc
   import adaptive_filter_pkg::*;
#(
   parameter int IN_WL     = C_IN_WL,
   parameter int IN_FL     = C_IN_FL,
   parameter int OUT_WL    = C_OUT_WL,
   parameter int OUT_FL    = C_OUT_FL,
   parameter int COEF_WL   = C_COEF_WL,
   parameter int COEF_FL   = C_COEF_FL,
   parameter int TAPS      = C_TAPS,
   parameter int NUM_MODES = C_NUM_MODES,
   parameter int FB_DELAY  = C_FB_DELAY,
   parameter int ACC_GUARD = C_ACC_GUARD,
   parameter int MODE_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
   input  wire logic              clk,
   input  wire logic              srst,
   input  wire logic [MODE_W-1:0] mode,
   output logic                   busy,
   adaptive_fir_mc_if.slave       bus
);
   localparam int ACC_WL  = f_acc_wl(IN_WL, COEF_WL, TAPS, ACC_GUARD);
   localparam int ACC_FL  = IN_FL + COEF_FL;
   localparam int NPAIR   = TAPS / 2;
   localparam int PRE_WL  = IN_WL + 1;
   localparam int PROD_WL = PRE_WL + COEF_WL;
   localparam int FBP_WL  = ACC_WL + COEF_WL;
   localparam int CNT_W   = $clog2(TAPS);

   state_t                   r_state, w_state_nxt;
   logic [MODE_W-1:0]        r_mode_q, w_mode_q_nxt;
   logic [MODE_W-1:0]        r_mode_tgt, w_mode_tgt_nxt;
   logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
   logic signed [IN_WL-1:0]  r_dl [TAPS-1];
   logic signed [ACC_WL-1:0] r_hist [FB_DELAY];
   logic signed [OUT_WL-1:0] r_m_tdata;
   logic                     r_m_tvalid;
   logic                     r_m_tovf;

   logic signed [IN_WL-1:0]   w_x [TAPS];
   logic signed [PROD_WL-1:0] w_prod [NPAIR+1];
   logic signed [FBP_WL-1:0]  w_fb_full;
   logic signed [ACC_WL-1:0]  w_fb;
   logic signed [ACC_WL-1:0]  w_acc;
   logic signed [OUT_WL-1:0]  w_rs_data;
   logic                      w_rs_ovf;
   logic                      w_accept;
   logic                      w_mode_valid;
   mode_cfg_t                 w_cfg;

   assign bus.s_tready = (r_state == ST_RUN);
   assign busy         = (r_state == ST_FLUSH);
   assign bus.m_tdata  = r_m_tdata;
   assign bus.m_tvalid = r_m_tvalid;
   assign bus.m_tovf   = r_m_tovf;

   assign w_accept     = bus.s_tvalid & bus.s_tready;
   assign w_mode_valid = (int'(mode) < NUM_MODES);
   assign w_cfg        = MODE_CFG[r_mode_q];

   assign w_x[0] = bus.s_tdata;
   for (genvar k = 1; k < TAPS; k++) begin : g_tap
      assign w_x[k] = r_dl[k-1];
   end

   for (genvar k = 0; k < NPAIR; k++) begin : g_pair
      logic signed [PRE_WL-1:0] w_pre;
      assign w_pre = w_cfg.symmetric ? (PRE_WL'(w_x[k]) + PRE_WL'(w_x[TAPS-1-k]))
                                     : (PRE_WL'(w_x[k]) - PRE_WL'(w_x[TAPS-1-k]));
      assign w_prod[k] = PROD_WL'(w_pre) * PROD_WL'($signed(w_cfg.coef[k]));
   end
   assign w_prod[NPAIR] = PROD_WL'(w_x[NPAIR]) * PROD_WL'($signed(w_cfg.coef[NPAIR]));

   // Feedback product carries COEF_FL extra fraction bits; drop them to return to ACC_FL
   assign w_fb_full = FBP_WL'($signed(w_cfg.fb_coef)) * FBP_WL'(r_hist[FB_DELAY-1]);
   assign w_fb      = w_cfg.fb_en ? ACC_WL'(w_fb_full >>> COEF_FL) : '0;

   always_comb begin
      w_acc = w_fb;
      for (int i = 0; i <= NPAIR; i++) begin
         w_acc = w_acc + ACC_WL'(w_prod[i]);
      end
   end

   fxp_round_sat #(
      .IN_WL  (ACC_WL),
      .IN_FL  (ACC_FL),
      .OUT_WL (OUT_WL),
      .OUT_FL (OUT_FL)
   ) u_round_sat (
      .i_acc  (w_acc),
      .o_data (w_rs_data),
      .o_ovf  (w_rs_ovf)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_mode_q_nxt   = r_mode_q;
      w_mode_tgt_nxt = r_mode_tgt;
      case (r_state)
         ST_RUN: begin
            if (w_mode_valid && (mode != r_mode_q)) begin
               w_state_nxt    = ST_FLUSH;
               w_cnt_nxt      = CNT_W'(TAPS - 1);
               w_mode_tgt_nxt = mode;
            end
         end
         ST_FLUSH: begin
            // A further mode change restarts the full flush towards the new target
            if (w_mode_valid && (mode != r_mode_tgt)) begin
               w_cnt_nxt      = CNT_W'(TAPS - 1);
               w_mode_tgt_nxt = mode;
            end else if (r_cnt == '0) begin
               w_state_nxt  = ST_RUN;
               w_mode_q_nxt = r_mode_tgt;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         r_state    <= ST_RUN;
         r_cnt      <= '0;
         r_mode_q   <= '0;
         r_mode_tgt <= '0;
         r_m_tdata  <= '0;
         r_m_tvalid <= 1'b0;
         r_m_tovf   <= 1'b0;
         for (int i = 0; i < TAPS - 1; i++) r_dl[i] <= '0;
         for (int i = 0; i < FB_DELAY; i++) r_hist[i] <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_mode_q   <= w_mode_q_nxt;
         r_mode_tgt <= w_mode_tgt_nxt;
         r_m_tvalid <= w_accept;
         if (r_state == ST_FLUSH) begin
            for (int i = 0; i < TAPS - 1; i++) r_dl[i] <= '0;
            for (int i = 0; i < FB_DELAY; i++) r_hist[i] <= '0;
         end else if (w_accept) begin
            r_m_tdata <= w_rs_data;
            r_m_tovf  <= w_rs_ovf;
            r_dl[0]   <= bus.s_tdata;
            for (int i = 1; i < TAPS - 1; i++) r_dl[i] <= r_dl[i-1];
            r_hist[0] <= w_acc;
            for (int i = 1; i < FB_DELAY; i++) r_hist[i] <= r_hist[i-1];
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_adaptive_fir_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adaptive_fir_mc
//  Purpose  : Directed and randomized checks of adaptive_fir_mc against an
//             unfolded tap-by-tap reference model.
//  Revision : 1.0
// ============================================================================
module tb_adaptive_fir_mc;

   logic       clk = 1'b0;
   logic       srst;
   logic [0:0] mode;
   logic       busy;

   adaptive_fir_mc_if #(.IN_WL(14), .OUT_WL(14)) bus ();

   adaptive_fir_mc dut (
      .clk  (clk),
      .srst (srst),
      .mode (mode),
      .busy (busy),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int     n_vec = 0;
   int     n_err = 0;
   int     mx [11];
   longint mh [2];
   int     mq;
   int     cf [2][6] = '{'{164, -492, 1311, -3277, 9830, 0},
                         '{164, 328, 655, 983, 1311, 1638}};
   bit     sym  [2] = '{1'b0, 1'b1};
   bit     fben [2] = '{1'b0, 1'b1};
   int     fbc  [2] = '{0, 16384};
   int     out_q [$];
   int     ref_q [$];
   int     n_acc;
   int     n_vld;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear(input int m);
      for (int j = 0; j < 11; j++) mx[j] = 0;
      mh[0] = 0;
      mh[1] = 0;
      mq    = m;
   endtask

   // Direct-form impulse response: h[j] for j = 0..10, mirrored by symmetry
   task automatic model_step(input int x, output int y, output bit ovf);
      longint acc;
      longint r;
      int     h;
      for (int j = 10; j > 0; j--) mx[j] = mx[j-1];
      mx[0] = x;
      acc = 0;
      for (int j = 0; j < 11; j++) begin
         if (j <= 5) h = cf[mq][j];
         else        h = sym[mq] ? cf[mq][10-j] : -cf[mq][10-j];
         acc += longint'(h) * longint'(mx[j]);
      end
      if (fben[mq]) acc += (longint'(fbc[mq]) * mh[1]) >>> 14;
      acc   = (acc <<< 25) >>> 25;
      mh[1] = mh[0];
      mh[0] = acc;
      r     = (acc + 64'sd8192) >>> 14;
      ovf   = 1'b0;
      if (r > 8191) begin
         r   = 8191;
         ovf = 1'b1;
      end else if (r < -8192) begin
         r   = -8192;
         ovf = 1'b1;
      end
      y = int'(r);
   endtask

   task automatic apply(input bit v, input int x);
      bit acc;
      int ey;
      bit eo;
      ey = 0;
      eo = 1'b0;
      bus.s_tvalid = v;
      bus.s_tdata  = 14'(x);
      acc = v && (bus.s_tready === 1'b1);
      if (acc) begin
         model_step(x, ey, eo);
         n_acc++;
      end
      tick();
      chk("m_tvalid", int'(bus.m_tvalid), int'(acc));
      if (bus.m_tvalid === 1'b1) n_vld++;
      if (acc) begin
         chk("m_tdata", int'(bus.m_tdata), ey);
         chk("m_tovf", int'(bus.m_tovf), int'(eo));
         out_q.push_back(int'(bus.m_tdata));
      end
   endtask

   task automatic wait_flush(input int newm);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         chk("flush_ready", int'(bus.s_tready), 0);
         n++;
         apply(1'b1, int'($urandom_range(0, 255)));
      end
      chk("flush_len", n, 11);
      model_clear(newm);
   endtask

   task automatic do_reset();
      srst         = 1'b1;
      bus.s_tvalid = 1'b0;
      tick();
      tick();
      srst = 1'b0;
      model_clear(0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int prev;
      int xs [40];
      int i;
      int guard;
      bit v;
      bit will;

      srst         = 1'b1;
      mode         = 1'b0;
      bus.s_tvalid = 1'b0;
      bus.s_tdata  = '0;
      n_acc        = 0;
      n_vld        = 0;
      model_clear(0);
      tick();
      tick();
      chk("rst_s_tready", int'(bus.s_tready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_m_tvalid", int'(bus.m_tvalid), 0);
      chk("rst_m_tdata", int'(bus.m_tdata), 0);
      chk("rst_m_tovf", int'(bus.m_tovf), 0);
      srst = 1'b0;

      // Mode 0 impulse response
      apply(1'b1, 64);
      for (int k = 0; k < 15; k++) apply(1'b1, 0);

      // Mode 1 step: ramp via recursive tap
      mode = 1'b1;
      apply(1'b0, 0);
      chk("busy_enter", int'(busy), 1);
      wait_flush(1);
      prev = -9000;
      for (int k = 0; k < 32; k++) begin
         apply(1'b1, 64);
         chk("monotonic", int'(int'(bus.m_tdata) >= prev), 1);
         prev = int'(bus.m_tdata);
      end

      // Saturation, positive then negative
      for (int k = 0; k < 20; k++) apply(1'b1, 8191);
      chk("sat_pos", int'(bus.m_tdata), 8191);
      chk("sat_pos_ovf", int'(bus.m_tovf), 1);
      do_reset();
      apply(1'b0, 0);
      wait_flush(1);
      for (int k = 0; k < 40; k++) apply(1'b1, -8192);
      chk("sat_neg", int'(bus.m_tdata), -8192);
      chk("sat_neg_ovf", int'(bus.m_tovf), 1);

      // Mode change 0 -> 1 on an accepting cycle
      mode = 1'b0;
      do_reset();
      for (int k = 0; k < 12; k++) apply(1'b1, int'($urandom_range(0, 4095)) - 2048);
      mode = 1'b1;
      apply(1'b1, int'($urandom_range(0, 4095)) - 2048);
      chk("busy_mid", int'(busy), 1);
      wait_flush(1);
      for (int k = 0; k < 6; k++) apply(1'b1, int'($urandom_range(0, 4095)) - 2048);

      // Gapped vs back-to-back delivery of the same stimulus
      for (int k = 0; k < 40; k++) xs[k] = int'($urandom_range(0, 2047)) - 1024;
      do_reset();
      apply(1'b0, 0);
      wait_flush(1);
      out_q.delete();
      for (int k = 0; k < 40; k++) apply(1'b1, xs[k]);
      ref_q = out_q;
      do_reset();
      apply(1'b0, 0);
      wait_flush(1);
      out_q.delete();
      n_acc = 0;
      n_vld = 0;
      i     = 0;
      guard = 0;
      while (i < 40 && guard < 2000) begin
         v    = ($urandom_range(0, 99) < 30);
         will = v && (bus.s_tready === 1'b1);
         apply(v, xs[i]);
         if (will) i++;
         guard++;
      end
      apply(1'b0, 0);
      chk("gap_out_count", out_q.size(), 40);
      chk("gap_vld_vs_acc", n_vld, n_acc);
      for (int k = 0; k < 40; k++) begin
         chk("gap_seq", (k < out_q.size()) ? out_q[k] : -99999, ref_q[k]);
      end

      // Reset in the middle of a flush
      mode = 1'b0;
      do_reset();
      apply(1'b1, 500);
      mode = 1'b1;
      apply(1'b0, 0);
      apply(1'b0, 0);
      apply(1'b0, 0);
      chk("busy_before_rst", int'(busy), 1);
      srst = 1'b1;
      tick();
      chk("midrst_s_tready", int'(bus.s_tready), 1);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_m_tdata", int'(bus.m_tdata), 0);
      chk("midrst_m_tvalid", int'(bus.m_tvalid), 0);
      srst = 1'b0;
      model_clear(0);
      apply(1'b0, 0);
      chk("modeq_zero_after_rst", int'(busy), 1);
      wait_flush(1);
      apply(1'b1, 64);
      for (int k = 0; k < 5; k++) apply(1'b1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
